reg_bank: RTL
=============

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter W, 8: data width of every register, the ALU result and the data bus.
REQ-002 Parameter NREG, 4: number of registers in the bank (A, B, C, D ordering; index 0 = A); legal 1..8.
REQ-003 Parameter SETTLE_CYCLES, 3: relay settle time in clocks; legal 1..15.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ld  input  NREG  one-hot-or-multi load request per register (ldA, ldB, ...).
REQ-007 sel  input  NREG  select request per register (selA, selB, ...); drives contents onto data bus.
REQ-008 ld_src  input  1  load source: 0 = alu_result, 1 = bus_in.
REQ-009 alu_result  input  W  ALU output.
REQ-010 bus_in  input  W  data bus value as seen by the bank.
REQ-011 data_out  output  W  value driven onto data bus.
REQ-012 data_oe  output  1  data_out valid/driving; data_out is 0 when data_oe is 0.
REQ-013 busy  output  1  operation in progress; new requests ignored.
REQ-014 done  output  1  one-cycle pulse on operation commit.
REQ-015 led_ld  output  NREG  mirror of latched ld vector for the front panel.
REQ-016 led_sel  output  NREG  mirror of latched sel vector for the front panel.
REQ-017 contents  output  NREG*W  all register values, register i at bits [i*W +: W], for panel lamps.

Function
REQ-018 FSM states IDLE, SETTLE, COMMIT; IDLE on reset.
REQ-019 In IDLE, (|ld | |sel) accepts a request: latch ld, sel, ld_src and load operand (alu_result or bus_in per ld_src) that cycle; go to SETTLE.
REQ-020 In IDLE with no request: busy=0, data_oe=0, led_ld=led_sel=0.
REQ-021 SETTLE lasts exactly SETTLE_CYCLES clocks (down-counter), then COMMIT; busy=1 throughout.
REQ-022 COMMIT lasts one clock: every register with latched ld bit set takes the latched operand; done=1; busy=1; next state IDLE.
REQ-023 Latency: accept at edge N, done high in cycle N+SETTLE_CYCLES+1, new contents visible in cycle N+SETTLE_CYCLES+2.
REQ-024 data_oe=1 from the cycle after accept through COMMIT when latched sel is non-zero.
REQ-025 data_out = bitwise OR of all registers with latched sel bit set (wired-OR relay bus).
REQ-026 Same register both loaded and selected: data_out shows pre-load content through COMMIT.
REQ-027 Multiple ld bits: all flagged registers receive the same operand.
REQ-028 ld, sel, ld_src, alu_result, bus_in changes while busy are ignored; no queuing.
REQ-029 led_ld/led_sel show latched vectors while busy, 0 in IDLE.

Reset
REQ-030 reset in any state, including mid-SETTLE or COMMIT: all registers 0, FSM IDLE, counter 0, no commit of the pending load.
REQ-031 Reset values: data_out=0, data_oe=0, busy=0, done=0, led_ld=0, led_sel=0, contents=0.
REQ-032 A request present in the cycle reset deasserts is not accepted until the following cycle.

Configuration
REQ-033 Macro REG_BANK_RELAY_TIMING_EN defined: SETTLE state and counter exist as in REQ-021.
REQ-034 Macro not defined: SETTLE and counter omitted, IDLE -> COMMIT directly, done one cycle after accept; SETTLE_CYCLES ignored; all other requirements unchanged.

Verification
REQ-035 Reset, ld=0001, ld_src=0, alu_result=0x5A -> done at accept+4 (SETTLE_CYCLES=3), contents A=0x5A, others 0.
REQ-036 A=0x0F, B=0xF0, sel=0011 -> data_oe=1 for 4 cycles, data_out=0xFF, done once, contents unchanged.
REQ-037 A=0x33, ld=sel=0001, ld_src=1, bus_in=0xC4 -> data_out=0x33 until COMMIT, A=0xC4 afterward.
REQ-038 ld=0110 with alu_result=0x81, then new ld=1000 asserted while busy -> B=C=0x81, D unchanged at 0.
REQ-039 ld=0001, alu_result=0x77, reset asserted in second SETTLE cycle -> A=0, no done pulse, all outputs 0.
REQ-040 Build without REG_BANK_RELAY_TIMING_EN, ld=0010, alu_result=0x12 -> done cycle after accept, B=0x12 next cycle.

Source files
------------

// File: rtl/reg_bank_if.sv
// Register bank bus: load/select requests in, wired-OR data bus and panel
// lamp signals out. Master drives requests, slave is the bank.
interface reg_bank_if #(
    parameter int W    = 8,
    parameter int NREG = 4
);
    logic [NREG-1:0]   ld;
    logic [NREG-1:0]   sel;
    logic              ld_src;
    logic [W-1:0]      alu_result;
    logic [W-1:0]      bus_in;
    logic [W-1:0]      data_out;
    logic              data_oe;
    logic              busy;
    logic              done;
    logic [NREG-1:0]   led_ld;
    logic [NREG-1:0]   led_sel;
    logic [NREG*W-1:0] contents;

    modport master (
        output ld, sel, ld_src, alu_result, bus_in,
        input  data_out, data_oe, busy, done, led_ld, led_sel, contents
    );

    modport slave (
        input  ld, sel, ld_src, alu_result, bus_in,
        output data_out, data_oe, busy, done, led_ld, led_sel, contents
    );
endinterface

// File: rtl/reg_bank.sv
// Relay-style register bank. A request (any ld or sel bit) is latched in
// IDLE, optionally waits out the relay settle time, then commits the load
// in a single COMMIT cycle. Selected registers are wired-OR onto data_out
// while busy, always showing the pre-load contents.
// Build option: define REG_BANK_RELAY_TIMING_EN to include the SETTLE state
// and its down-counter; without it IDLE goes straight to COMMIT.
module reg_bank #(
    parameter int W             = 8,
    parameter int NREG          = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    reg_bank_if.slave   rb
);

    if (NREG < 1 || NREG > 8 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_param_check
        $error("reg_bank: NREG must be 1..8 and SETTLE_CYCLES 1..15");
    end

`ifdef REG_BANK_RELAY_TIMING_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, COMMIT = 2'd2} state_t;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
    logic [3:0] cnt;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, COMMIT = 2'd2} state_t;
`endif

    state_t                 state, state_d;
    logic                   accept;
    logic                   busy;
    logic [NREG-1:0]        ld_q, sel_q;
    logic [W-1:0]           op_q;
    logic [NREG-1:0][W-1:0] regs;
    logic [W-1:0]           wired_or;

    // Next state; a request is only taken while idle
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if ((|rb.ld) || (|rb.sel)) begin
                    accept  = 1'b1;
`ifdef REG_BANK_RELAY_TIMING_EN
                    state_d = SETTLE;
`else
                    state_d = COMMIT;
`endif
                end
            end
`ifdef REG_BANK_RELAY_TIMING_EN
            SETTLE: if (cnt == 4'd0) state_d = COMMIT;
`endif
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

`ifdef REG_BANK_RELAY_TIMING_EN
    // Settle down-counter: loaded on accept so SETTLE spans SETTLE_CYCLES clocks
    always_ff @(posedge clk) begin
        if (reset)                               cnt <= 4'd0;
        else if (accept)                         cnt <= CNT_INIT;
        else if (state == SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
`endif

    // Request latch and register file; a reset during COMMIT drops the load
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_q  <= '0;
            sel_q <= '0;
            op_q  <= '0;
            regs  <= '0;
        end else begin
            if (accept) begin
                ld_q  <= rb.ld;
                sel_q <= rb.sel;
                op_q  <= rb.ld_src ? rb.bus_in : rb.alu_result;
            end
            if (state == COMMIT) begin
                for (int i = 0; i < NREG; i++)
                    if (ld_q[i]) regs[i] <= op_q;
            end
        end
    end

    // Wired-OR relay bus of all selected registers
    always_comb begin
        wired_or = '0;
        for (int i = 0; i < NREG; i++)
            if (sel_q[i]) wired_or = wired_or | regs[i];
    end

    assign busy        = (state != IDLE);
    assign rb.busy     = busy;
    assign rb.done     = (state == COMMIT);
    assign rb.data_oe  = busy && (|sel_q);
    assign rb.data_out = rb.data_oe ? wired_or : '0;
    assign rb.led_ld   = busy ? ld_q  : '0;
    assign rb.led_sel  = busy ? sel_q : '0;
    assign rb.contents = regs;

endmodule
